dag_circ_top: RTL and testbench

- Parametrised successor of the two-DAG address generator. DAG1 (ps_dg_dgsclt=0) produces data-memory addresses. DAG2 (ps_dg_dgsclt=1) produces program-memory addresses.
- Generalised width and register count. Adds length (L) and base (B) registers for circular buffering.
- Address outputs are registered with valid strobes.
- Sits between the program sequencer (control, register addresses) and the broadcast data bus (bc_dt).

---
 rtl/dag_circ_top.sv | 142 ++++++++++++++
 tb/tb_dag_circ_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dag_circ_top.sv
// Purpose: two-DAG address generator (DAG1 -> DM, DAG2 -> PS) with circular buffering via I/M/L/B registers.
// Latency: one cycle from request to registered address + vld pulse; register read port is combinational.
// Backpressure: none; one request per cycle always accepted. Optional macro DAG_BITREV_EN adds ps_dg_brev.
module dag_circ_top #(
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int IW   = $clog2(NREG),
  parameter int RA   = IW + 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [IW-1:0] ps_dg_iadd,
  input  logic [IW-1:0] ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [RA-1:0] ps_dg_wrt_add,
  input  logic [RA-1:0] ps_dg_rd_add,
  input  logic [AW-1:0] bc_dt,
`ifdef DAG_BITREV_EN
  input  logic          ps_dg_brev,
`endif
  output logic [AW-1:0] dg_dm_add,
  output logic          dg_dm_vld,
  output logic [AW-1:0] dg_ps_add,
  output logic          dg_ps_vld,
  output logic [AW-1:0] dg_bc_dt
);

  localparam int NR = 2 * NREG;
  localparam logic [1:0] CLS_M = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;
  localparam logic [1:0] CLS_L = 2'b10;
  localparam logic [1:0] CLS_B = 2'b11;

  logic [AW-1:0] i_reg [NR];
  logic [AW-1:0] m_reg [NR];
  logic [AW-1:0] l_reg [NR];
  logic [AW-1:0] b_reg [NR];

  logic [1:0]    wr_cls, rd_cls;
  logic [IW:0]   wr_idx, rd_idx, ai, am;
  logic [AW-1:0] op_i, op_m, op_l, op_b;
  logic [AW+1:0] sum, base, lim, wrapped;
  logic [AW-1:0] i_next, addr_sel, addr_out;

  // Decode addresses and pick operands, forwarding a same-cycle write of any used register.
  always_comb begin
    wr_cls = ps_dg_wrt_add[RA-1 -: 2];
    wr_idx = ps_dg_wrt_add[IW:0];
    ai     = {ps_dg_dgsclt, ps_dg_iadd};
    am     = {ps_dg_dgsclt, ps_dg_madd};
    op_i   = i_reg[ai];
    op_m   = m_reg[am];
    op_l   = l_reg[ai];
    op_b   = b_reg[ai];
    if (ps_dg_wrt_en) begin
      // a B write also loads the same-index I, so it forwards into I as well
      if (wr_idx == ai && (wr_cls == CLS_I || wr_cls == CLS_B)) op_i = bc_dt;
      if (wr_idx == am && wr_cls == CLS_M) op_m = bc_dt;
      if (wr_idx == ai && wr_cls == CLS_L) op_l = bc_dt;
      if (wr_idx == ai && wr_cls == CLS_B) op_b = bc_dt;
    end
  end

  // Modify arithmetic and circular wrap; two guard bits keep an underflow below zero visibly negative.
  always_comb begin
    sum     = {2'b00, op_i} + {{2{op_m[AW-1]}}, op_m};
    base    = {2'b00, op_b};
    lim     = {2'b00, op_b} + {2'b00, op_l};
    wrapped = sum;
    if (op_l != '0) begin
      if ($signed(sum) >= $signed(lim))      wrapped = sum - {2'b00, op_l};
      else if ($signed(sum) < $signed(base)) wrapped = sum + {2'b00, op_l};
    end
    i_next   = wrapped[AW-1:0];
    // pre-modify emits the unwrapped sum; post-modify emits the current I
    addr_sel = ps_dg_mdfy ? sum[AW-1:0] : op_i;
  end

`ifdef DAG_BITREV_EN
  // Optional bit reversal of the emitted address only; the I update stays in natural order.
  always_comb begin
    addr_out = addr_sel;
    if (ps_dg_brev) begin
      for (int k = 0; k < AW; k++) addr_out[k] = addr_sel[AW-1-k];
    end
  end
`else
  assign addr_out = addr_sel;
`endif

  // Register read port with write-through bypass on an exact address match.
  always_comb begin
    rd_cls   = ps_dg_rd_add[RA-1 -: 2];
    rd_idx   = ps_dg_rd_add[IW:0];
    dg_bc_dt = '0;
    case (rd_cls)
      CLS_M:   dg_bc_dt = m_reg[rd_idx];
      CLS_I:   dg_bc_dt = i_reg[rd_idx];
      CLS_L:   dg_bc_dt = l_reg[rd_idx];
      default: dg_bc_dt = b_reg[rd_idx];
    endcase
    if (ps_dg_wrt_en && ps_dg_wrt_add == ps_dg_rd_add) dg_bc_dt = bc_dt;
  end

  // Register file writes, post-modify I update (wins over a colliding write) and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dg_dm_add <= '0;
      dg_ps_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_ps_vld <= 1'b0;
    end else begin
      if (ps_dg_wrt_en) begin
        case (wr_cls)
          CLS_M:   m_reg[wr_idx] <= bc_dt;
          CLS_I:   i_reg[wr_idx] <= bc_dt;
          CLS_L:   l_reg[wr_idx] <= bc_dt;
          default: begin
            b_reg[wr_idx] <= bc_dt;
            i_reg[wr_idx] <= bc_dt;
          end
        endcase
      end
      // later assignment wins: the update already used the forwarded write value
      if (ps_dg_en && !ps_dg_mdfy) i_reg[ai] <= i_next;
      dg_dm_vld <= ps_dg_en && !ps_dg_dgsclt;
      dg_ps_vld <= ps_dg_en && ps_dg_dgsclt;
      if (ps_dg_en && !ps_dg_dgsclt) dg_dm_add <= addr_out;
      if (ps_dg_en && ps_dg_dgsclt)  dg_ps_add <= addr_out;
    end
  end

endmodule

// File: tb/tb_dag_circ_top.sv
// Directed bench for dag_circ_top: circular/linear post-modify, pre-modify on DAG2,
// operand forwarding, read bypass, mid-stream reset, and optional bit reversal.
module tb_dag_circ_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy;
  logic [2:0]  ps_dg_iadd, ps_dg_madd;
  logic        ps_dg_wrt_en;
  logic [5:0]  ps_dg_wrt_add, ps_dg_rd_add;
  logic [15:0] bc_dt;
  logic        ps_dg_brev;
  logic [15:0] dg_dm_add, dg_ps_add, dg_bc_dt;
  logic        dg_dm_vld, dg_ps_vld;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dag_circ_top #(.AW(16), .NREG(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps_dg_en      (ps_dg_en),
    .ps_dg_dgsclt  (ps_dg_dgsclt),
    .ps_dg_mdfy    (ps_dg_mdfy),
    .ps_dg_iadd    (ps_dg_iadd),
    .ps_dg_madd    (ps_dg_madd),
    .ps_dg_wrt_en  (ps_dg_wrt_en),
    .ps_dg_wrt_add (ps_dg_wrt_add),
    .ps_dg_rd_add  (ps_dg_rd_add),
    .bc_dt         (bc_dt),
`ifdef DAG_BITREV_EN
    .ps_dg_brev    (ps_dg_brev),
`endif
    .dg_dm_add     (dg_dm_add),
    .dg_dm_vld     (dg_dm_vld),
    .dg_ps_add     (dg_ps_add),
    .dg_ps_vld     (dg_ps_vld),
    .dg_bc_dt      (dg_bc_dt)
  );

  function automatic logic [5:0] ra(input logic [1:0] c, input logic d, input logic [2:0] x);
    return {c, d, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    ps_dg_wrt_en  = 1'b1;
    ps_dg_wrt_add = a;
    bc_dt         = d;
    tick();
    ps_dg_wrt_en  = 1'b0;
    bc_dt         = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    ps_dg_rd_add = a;
    #1;
    d = dg_bc_dt;
  endtask

  task automatic req(input logic dag, input logic mdfy, input logic [2:0] ii, input logic [2:0] mi);
    ps_dg_en     = 1'b1;
    ps_dg_dgsclt = dag;
    ps_dg_mdfy   = mdfy;
    ps_dg_iadd   = ii;
    ps_dg_madd   = mi;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0;
    tick();
    n_chk++; if (dg_dm_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dm_vld got %b exp 0", dg_dm_vld); end
    n_chk++; if (dg_ps_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ps_vld got %b exp 0", dg_ps_vld); end
    n_chk++; if (dg_dm_add !== 16'h0) begin n_fail++; $display("FAIL reset_dm_add got %h exp 0000", dg_dm_add); end
    n_chk++; if (dg_ps_add !== 16'h0) begin n_fail++; $display("FAIL reset_ps_add got %h exp 0000", dg_ps_add); end
    rst_n = 1'b1;
    tick();
    rd(ra(2'b11, 1'b1, 3'd7), v);
    n_chk++; if (v !== 16'h0) begin n_fail++; $display("FAIL reset_b15 got %h exp 0000", v); end
  endtask

  task automatic test_circular();
    logic [15:0] exp_a [5];
    logic [15:0] v;
    exp_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0100};
    wr(ra(2'b11, 1'b0, 3'd0), 16'h0100);
    wr(ra(2'b10, 1'b0, 3'd0), 16'h0004);
    wr(ra(2'b00, 1'b0, 3'd0), 16'h0001);
    rd(ra(2'b01, 1'b0, 3'd0), v);
    n_chk++; if (v !== 16'h0100) begin n_fail++; $display("FAIL circ_b_sets_i got %h exp 0100", v); end
    for (int k = 0; k < 5; k++) begin
      req(1'b0, 1'b0, 3'd0, 3'd0);
      tick();
      n_chk++; if (dg_dm_add !== exp_a[k]) begin n_fail++; $display("FAIL circ_add[%0d] got %h exp %h", k, dg_dm_add, exp_a[k]); end
      n_chk++; if (dg_dm_vld !== 1'b1) begin n_fail++; $display("FAIL circ_vld[%0d] got %b exp 1", k, dg_dm_vld); end
      n_chk++; if (dg_ps_vld !== 1'b0) begin n_fail++; $display("FAIL circ_ps_vld[%0d] got %b exp 0", k, dg_ps_vld); end
    end
    ps_dg_en = 1'b0;
    tick();
    n_chk++; if (dg_dm_vld !== 1'b0) begin n_fail++; $display("FAIL idle_vld got %b exp 0", dg_dm_vld); end
    n_chk++; if (dg_dm_add !== 16'h0100) begin n_fail++; $display("FAIL idle_hold got %h exp 0100", dg_dm_add); end
    rd(ra(2'b01, 1'b0, 3'd0), v);
    n_chk++; if (v !== 16'h0101) begin n_fail++; $display("FAIL circ_i_after got %h exp 0101", v); end
  endtask

  task automatic test_negative_linear();
    logic [15:0] v;
    wr(ra(2'b11, 1'b0, 3'd1), 16'h0100);
    wr(ra(2'b10, 1'b0, 3'd1), 16'h0004);
    wr(ra(2'b00, 1'b0, 3'd1), 16'hFFFF);
    req(1'b0, 1'b0, 3'd1, 3'd1);
    tick();
    n_chk++; if (dg_dm_add !== 16'h0100) begin n_fail++; $display("FAIL neg_add0 got %h exp 0100", dg_dm_add); end
    tick();
    n_chk++; if (dg_dm_add !== 16'h0103) begin n_fail++; $display("FAIL neg_add1 got %h exp 0103", dg_dm_add); end
    ps_dg_en = 1'b0;
    rd(ra(2'b01, 1'b0, 3'd1), v);
    n_chk++; if (v !== 16'h0102) begin n_fail++; $display("FAIL neg_i got %h exp 0102", v); end
    wr(ra(2'b01, 1'b0, 3'd3), 16'hFFFF);
    wr(ra(2'b00, 1'b0, 3'd3), 16'h0001);
    req(1'b0, 1'b0, 3'd3, 3'd3);
    tick();
    ps_dg_en = 1'b0;
    n_chk++; if (dg_dm_add !== 16'hFFFF) begin n_fail++; $display("FAIL lin_add got %h exp ffff", dg_dm_add); end
    rd(ra(2'b01, 1'b0, 3'd3), v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL lin_i got %h exp 0000", v); end
  endtask

  task automatic test_premodify();
    logic [15:0] v;
    wr(ra(2'b01, 1'b1, 3'd0), 16'h0020);
    wr(ra(2'b00, 1'b1, 3'd0), 16'h0003);
    req(1'b1, 1'b1, 3'd0, 3'd0);
    tick();
    ps_dg_en = 1'b0;
    n_chk++; if (dg_ps_add !== 16'h0023) begin n_fail++; $display("FAIL pre_ps_add got %h exp 0023", dg_ps_add); end
    n_chk++; if (dg_ps_vld !== 1'b1) begin n_fail++; $display("FAIL pre_ps_vld got %b exp 1", dg_ps_vld); end
    n_chk++; if (dg_dm_vld !== 1'b0) begin n_fail++; $display("FAIL pre_dm_vld got %b exp 0", dg_dm_vld); end
    n_chk++; if (dg_dm_add !== 16'hFFFF) begin n_fail++; $display("FAIL pre_dm_hold got %h exp ffff", dg_dm_add); end
    rd(ra(2'b01, 1'b1, 3'd0), v);
    n_chk++; if (v !== 16'h0020) begin n_fail++; $display("FAIL pre_i_kept got %h exp 0020", v); end
  endtask

  task automatic test_forwarding();
    logic [15:0] v;
    wr(ra(2'b00, 1'b0, 3'd2), 16'h0002);
    ps_dg_wrt_en  = 1'b1;
    ps_dg_wrt_add = ra(2'b01, 1'b0, 3'd2);
    bc_dt         = 16'h0040;
    req(1'b0, 1'b0, 3'd2, 3'd2);
    rd(ra(2'b01, 1'b0, 3'd2), v);
    n_chk++; if (v !== 16'h0040) begin n_fail++; $display("FAIL fwd_bypass got %h exp 0040", v); end
    @(posedge clk);
    #1;
    ps_dg_wrt_en = 1'b0;
    ps_dg_en     = 1'b0;
    bc_dt        = '0;
    n_chk++; if (dg_dm_add !== 16'h0040) begin n_fail++; $display("FAIL fwd_add got %h exp 0040", dg_dm_add); end
    rd(ra(2'b01, 1'b0, 3'd2), v);
    n_chk++; if (v !== 16'h0042) begin n_fail++; $display("FAIL fwd_i got %h exp 0042", v); end
  endtask

  task automatic test_bitrev();
`ifdef DAG_BITREV_EN
    wr(ra(2'b01, 1'b0, 3'd4), 16'h0001);
    req(1'b0, 1'b0, 3'd4, 3'd4);
    ps_dg_brev = 1'b1;
    tick();
    ps_dg_en   = 1'b0;
    ps_dg_brev = 1'b0;
    n_chk++; if (dg_dm_add !== 16'h8000) begin n_fail++; $display("FAIL brev_add got %h exp 8000", dg_dm_add); end
`endif
  endtask

  task automatic test_reset_midstream();
    logic [15:0] v;
    req(1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    n_chk++; if (dg_dm_vld !== 1'b1) begin n_fail++; $display("FAIL mid_pre_vld got %b exp 1", dg_dm_vld); end
    rst_n         = 1'b0;
    ps_dg_wrt_en  = 1'b1;
    ps_dg_wrt_add = ra(2'b10, 1'b1, 3'd5);
    bc_dt         = 16'h1234;
    tick();
    rst_n        = 1'b1;
    ps_dg_en     = 1'b0;
    ps_dg_wrt_en = 1'b0;
    bc_dt        = '0;
    n_chk++; if (dg_dm_vld !== 1'b0) begin n_fail++; $display("FAIL mid_dm_vld got %b exp 0", dg_dm_vld); end
    n_chk++; if (dg_dm_add !== 16'h0) begin n_fail++; $display("FAIL mid_dm_add got %h exp 0000", dg_dm_add); end
    n_chk++; if (dg_ps_add !== 16'h0) begin n_fail++; $display("FAIL mid_ps_add got %h exp 0000", dg_ps_add); end
    for (int a = 0; a < 64; a++) begin
      rd(6'(a), v);
      n_chk++; if (v !== 16'h0) begin n_fail++; $display("FAIL mid_reg[%0d] got %h exp 0000", a, v); end
    end
  endtask

  initial begin
    rst_n = 1'b0; ps_dg_en = 1'b0; ps_dg_dgsclt = 1'b0; ps_dg_mdfy = 1'b0;
    ps_dg_iadd = '0; ps_dg_madd = '0; ps_dg_wrt_en = 1'b0; ps_dg_wrt_add = '0;
    ps_dg_rd_add = '0; bc_dt = '0; ps_dg_brev = 1'b0;
    test_reset();
    test_circular();
    test_negative_linear();
    test_premodify();
    test_forwarding();
    test_bitrev();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
